// File: rtl/stack_arbiter.sv
// Round-robin push/pop arbiter and sequencer for a shared falling-edge LIFO stack.
// Tracks occupancy locally and drives the stack's synchronous reset for init and flush.
module stack_arbiter #(
  parameter int  DATA_WIDTH = 8,
  parameter int  STACK_SIZE = 4,
  localparam int CW         = $clog2(STACK_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  op_a,
  input  logic                  op_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic                  flush,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [CW-1:0]         count,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_reset,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  output logic [2:0]            state_dbg
);

  // Handshake: a requester holds req/op/wdata until it sees its one-cycle gnt
  // pulse; the result arrives on the following cycle as a one-cycle rvalid pulse
  // with rdata/err valid alongside it.
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_RESP  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(STACK_SIZE);

  state_t                state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic                  win_b_q, win_b_d;
  logic                  op_q, op_d;
  logic                  rej_q, rej_d;
  logic [CW-1:0]         count_d;
  logic                  gnt_a_d, gnt_b_d, rvalid_a_d, rvalid_b_d, err_d;
  logic                  stk_push_d, stk_pop_d, stk_reset_d;
  logic [DATA_WIDTH-1:0] rdata_d, stk_wdata_d;
  logic                  pick_b, pick_op, pick_rej;
  logic [DATA_WIDTH-1:0] pick_wdata;

  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    win_b_d     = win_b_q;
    op_d        = op_q;
    rej_d       = rej_q;
    count_d     = count;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    stk_push_d  = 1'b0;
    stk_pop_d   = 1'b0;
    stk_reset_d = 1'b0;
    stk_wdata_d = '0;

    // On a tie the port that was not granted last wins.
    pick_b     = req_b & (~req_a | ~last_b_q);
    pick_op    = pick_b ? op_b : op_a;
    pick_wdata = pick_b ? wdata_b : wdata_a;
    pick_rej   = pick_op ? (count == '0) : (count == FULL);

    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (flush) begin
          state_d     = S_FLUSH;
          stk_reset_d = 1'b1;
        end else if (req_a | req_b) begin
          state_d    = S_ISSUE;
          win_b_d    = pick_b;
          last_b_d   = pick_b;
          op_d       = pick_op;
          rej_d      = pick_rej;
          gnt_a_d    = ~pick_b;
          gnt_b_d    = pick_b;
          stk_push_d = ~pick_op & ~pick_rej;
          stk_pop_d  = pick_op & ~pick_rej;
          if (~pick_op & ~pick_rej) stk_wdata_d = pick_wdata;
        end
      end
      S_ISSUE: begin
        // The stack acted on the falling edge inside ISSUE, so stk_rdata is settled here.
        state_d    = S_RESP;
        rvalid_a_d = ~win_b_q;
        rvalid_b_d = win_b_q;
        err_d      = rej_q;
        if (op_q & ~rej_q) rdata_d = stk_rdata;
        if (!rej_q) count_d = op_q ? count - CW'(1) : count + CW'(1);
      end
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      op_q      <= 1'b0;
      rej_q     <= 1'b0;
      count     <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_reset <= 1'b1;
      stk_wdata <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      op_q      <= op_d;
      rej_q     <= rej_d;
      count     <= count_d;
      gnt_a     <= gnt_a_d;
      gnt_b     <= gnt_b_d;
      rvalid_a  <= rvalid_a_d;
      rvalid_b  <= rvalid_b_d;
      err       <= err_d;
      rdata     <= rdata_d;
      stk_push  <= stk_push_d;
      stk_pop   <= stk_pop_d;
      stk_reset <= stk_reset_d;
      stk_wdata <= stk_wdata_d;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a falling-edge LIFO model on the stack side.
module tb_stack_arbiter;

  localparam int DW = 8;
  localparam int SS = 4;
  localparam int CW = $clog2(SS + 1);

  logic          clk, reset;
  logic          req_a, req_b, op_a, op_b, flush;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, err;
  logic [DW-1:0] rdata, stk_wdata, stk_rdata;
  logic [CW-1:0] count;
  logic          stk_push, stk_pop, stk_reset;
  logic [2:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int push_cnt = 0;
  int pop_cnt = 0;

  stack_arbiter #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .flush(flush),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .err(err), .count(count),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_reset(stk_reset),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // falling-edge LIFO model
  logic [DW-1:0] mem [SS];
  int sp = 0;
  initial stk_rdata = '0;
  always @(negedge clk) begin
    if (stk_reset) begin
      sp = 0;
      stk_rdata = '0;
    end else if (stk_push) begin
      if (sp < SS) begin
        mem[sp] = stk_wdata;
        sp = sp + 1;
      end
    end else if (stk_pop) begin
      if (sp > 0) begin
        stk_rdata = mem[sp-1];
        sp = sp - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle protocol monitor
  logic prev_ga = 0, prev_gb = 0, prev_ra = 0, prev_rb = 0;
  always @(negedge clk) begin
    if (stk_push) push_cnt++;
    if (stk_pop) pop_cnt++;
    chk("strobe_onehot", 32'($countones({stk_push, stk_pop, stk_reset}) <= 1), 1);
    chk("gnt_rvalid_onehot", 32'($countones({gnt_a, gnt_b, rvalid_a, rvalid_b}) <= 1), 1);
    chk("pulse_width", 32'((gnt_a & prev_ga) | (gnt_b & prev_gb) |
                           (rvalid_a & prev_ra) | (rvalid_b & prev_rb)), 0);
    prev_ga = gnt_a; prev_gb = gnt_b; prev_ra = rvalid_a; prev_rb = rvalid_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one request through grant and response
  task automatic do_op(input logic port_b, input logic op, input logic [DW-1:0] wd,
                       input logic exp_err, input logic [DW-1:0] exp_rdata,
                       input logic [CW-1:0] exp_count);
    int p0 = push_cnt;
    int q0 = pop_cnt;
    int lat = 0;
    logic got = 0;
    if (port_b) begin req_b = 1; op_b = op; wdata_b = wd; end
    else begin req_a = 1; op_a = op; wdata_a = wd; end
    while (!got && lat < 8) begin
      tick();
      lat++;
      if (gnt_a | gnt_b) got = 1;
    end
    chk("gnt_seen", 32'(got), 1);
    req_a = 0;
    req_b = 0;
    if (!got) return;
    chk("gnt_latency", lat, 1);
    chk("gnt_port", {30'd0, gnt_b, gnt_a}, port_b ? 2 : 1);
    tick();
    chk("rvalid_port", {30'd0, rvalid_b, rvalid_a}, port_b ? 2 : 1);
    chk("err", 32'(err), 32'(exp_err));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    chk("count", 32'(count), 32'(exp_count));
    chk("push_strobes", push_cnt - p0, (!op && !exp_err) ? 1 : 0);
    chk("pop_strobes", pop_cnt - q0, (op && !exp_err) ? 1 : 0);
    tick();
  endtask

  typedef struct {
    logic          port_b;
    logic          op;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ng;
    int last_c;
    int pc0;

    vecs[0] = '{0, 0, 8'h11, 0, 8'h00, 3'd1};
    vecs[1] = '{0, 0, 8'h22, 0, 8'h00, 3'd2};
    vecs[2] = '{0, 0, 8'h33, 0, 8'h00, 3'd3};
    vecs[3] = '{0, 0, 8'h44, 0, 8'h00, 3'd4};
    vecs[4] = '{0, 0, 8'h55, 1, 8'h00, 3'd4};
    vecs[5] = '{1, 1, 8'h00, 0, 8'h44, 3'd3};
    vecs[6] = '{1, 1, 8'h00, 0, 8'h33, 3'd2};
    vecs[7] = '{1, 1, 8'h00, 0, 8'h22, 3'd1};
    vecs[8] = '{1, 1, 8'h00, 0, 8'h11, 3'd0};
    vecs[9] = '{1, 1, 8'h00, 1, 8'h00, 3'd0};

    reset = 0; req_a = 0; req_b = 0; op_a = 0; op_b = 0;
    wdata_a = '0; wdata_b = '0; flush = 0;
    tick();
    tick();
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_stk_reset", 32'(stk_reset), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_outs", {22'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, err, stk_push, stk_pop,
                     |rdata, |stk_wdata, 1'b0}, 0);
    reset = 1;
    tick();
    chk("init_exit_state", 32'(state_dbg), 1);
    chk("init_exit_stk_reset", 32'(stk_reset), 0);

    // fill to full, overflow, drain, underflow
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].port_b, vecs[i].op, vecs[i].wdata,
            vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_count);

    // contention: both held, grants alternate A,B,A,B three cycles apart
    req_a = 1; op_a = 0; wdata_a = 8'hA1;
    req_b = 1; op_b = 0; wdata_b = 8'hB1;
    ng = 0;
    last_c = 0;
    for (int c = 0; c < 24 && ng < 4; c++) begin
      tick();
      if (gnt_a | gnt_b) begin
        chk("rr_port", {30'd0, gnt_b, gnt_a}, (ng % 2 == 0) ? 1 : 2);
        if (ng > 0) chk("rr_gap", c - last_c, 3);
        last_c = c;
        ng++;
      end
    end
    chk("rr_grants", ng, 4);
    req_a = 0; req_b = 0;
    tick();
    tick();
    chk("rr_count", 32'(count), 4);

    do_op(1, 1, 8'h00, 0, 8'hB1, 3'd3);
    do_op(1, 1, 8'h00, 0, 8'hA1, 3'd2);

    // flush has priority over a simultaneous request
    flush = 1; req_a = 1; op_a = 1;
    tick();
    chk("flush_stk_reset", 32'(stk_reset), 1);
    chk("flush_no_gnt", 32'(gnt_a | gnt_b), 0);
    chk("flush_state", 32'(state_dbg), 4);
    flush = 0;
    tick();
    chk("flush_pulse_end", 32'(stk_reset), 0);
    chk("flush_count", 32'(count), 0);
    do_op(0, 1, 8'h00, 1, 8'h00, 3'd0);

    // reset in the middle of a pop
    do_op(0, 0, 8'h01, 0, 8'h00, 3'd1);
    do_op(0, 0, 8'h02, 0, 8'h00, 3'd2);
    do_op(0, 0, 8'h03, 0, 8'h00, 3'd3);
    pc0 = pop_cnt;
    req_a = 1; op_a = 1;
    tick();
    chk("mid_gnt", 32'(gnt_a), 1);
    reset = 0;
    #1;
    chk("mid_stk_reset", 32'(stk_reset), 1);
    chk("mid_stk_pop", 32'(stk_pop), 0);
    chk("mid_count", 32'(count), 0);
    chk("mid_state", 32'(state_dbg), 0);
    req_a = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_no_rvalid", 32'(rvalid_a | rvalid_b), 0);
      chk("mid_hold_reset", 32'(stk_reset), 1);
    end
    chk("mid_no_pop", pop_cnt - pc0, 0);
    reset = 1;
    tick();
    chk("mid_release", 32'(stk_reset), 0);
    do_op(0, 1, 8'h00, 1, 8'h00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-requester arbiter and sequencer for the shared falling-edge LIFO stack. It accepts push/pop requests from ports A and B and grants them round-robin. It issues exactly one single-cycle push or pop strobe per granted request, returns popped data or an error flag to the winner, and tracks occupancy itself rather than trusting the stack's full/empty flags. It also initialises and flushes the stack through the stack's synchronous reset input.

## Interface
- DATA_WIDTH, 8, data width; must match the stack.
- STACK_SIZE, 4, stack depth; must match the stack.
- CW, $clog2(STACK_SIZE+1), occupancy counter width (derived, not overridden).
- clk  in  1  single clock; controller logic is posedge, the stack it drives updates on negedge.
- reset  in  1  asynchronous, active-low; clears all controller state immediately.
- req_a / req_b  in  1  request, held by requester until its gnt.
- op_a / op_b  in  1  0 = push, 1 = pop; stable while req high.
- wdata_a / wdata_b  in  DATA_WIDTH  push data; stable while req high.
- flush  in  1  clear the stack and occupancy; sampled only in IDLE.
- gnt_a / gnt_b  out  1  one-cycle grant pulse.
- rvalid_a / rvalid_b  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  popped data, valid with rvalid; shared by both ports.
- err  out  1  request rejected (push when full, pop when empty), valid with rvalid.
- count  out  CW  current occupancy 0..STACK_SIZE.
- stk_push / stk_pop / stk_reset  out  1  strobes to the stack; stk_reset is active-high.
- stk_wdata  out  DATA_WIDTH  data to the stack.
- stk_rdata  in  DATA_WIDTH  stack read_data.

## Operation
- All outputs are registered.
- FSM states are INIT, IDLE, ISSUE, RESP and FLUSH.
- INIT: entered while reset is low; stk_reset = 1. Moves to IDLE on the first posedge after release.
- IDLE, flush high: go to FLUSH. Flush has priority over requests.
- IDLE, any req: pick a winner and go to ISSUE.
  - One req: that port wins.
  - Both: the port not granted last wins. The last-granted pointer resets to B, so A wins the first tie.
  - Capture the winner's op and wdata.
- IDLE, no req: stay in IDLE.
- ISSUE, one cycle: gnt of the winner high.
  - Push with count < STACK_SIZE: stk_push = 1, stk_wdata = captured data.
  - Pop with count > 0: stk_pop = 1.
  - Otherwise the request is rejected: no strobe, and the error is latched.
  - count is updated (+1 or -1) at the end of ISSUE, and only for non-rejected ops.
- RESP, one cycle: rvalid of the winner high and err = latched error.
  - Non-rejected pop: rdata = stk_rdata captured at the ISSUE→RESP edge.
  - Push or rejected op: rdata = 0.
  - Go to IDLE.
- FLUSH, one cycle: stk_reset = 1 and count cleared to 0, then IDLE. No gnt or rvalid.
- req, op and wdata are ignored outside IDLE. At most one strobe (stk_push, stk_pop or stk_reset) is high in any cycle.
- The requester drops req after seeing gnt. A req still high back in IDLE is treated as a new request.

## Timing
- Reset values: state INIT, stk_reset 1, last-granted pointer B, all other outputs 0, count 0.
- Request sampled in IDLE at posedge N:
  - gnt and the strobe are high in cycle N+1.
  - The stack acts at the negedge inside cycle N+1.
  - rdata is captured at posedge N+2; rvalid, rdata and err are high in cycle N+2.
  - The FSM is back in IDLE in cycle N+3.
- Throughput is one operation per 3 cycles. Two contending requests complete in 6 cycles.
- count reflects the operation from cycle N+2 onward.
- Flush sampled at posedge N: stk_reset high in cycle N+1, count = 0 from cycle N+2.
- Reset asserted mid-operation:
  - Immediate abort; no rvalid for the in-flight request.
  - stk_reset is held high, so the stack clears at its next negedge.
  - count returns to 0.
- Boundaries:
  - Push at count = STACK_SIZE: err = 1, count unchanged, no stk_push.
  - Pop at count = 0: err = 1, rdata = 0, no stk_pop.

## Test plan
- Reset release, then A pushes 0x11, 0x22, 0x33, 0x44 (STACK_SIZE = 4) → four gnt_a/rvalid_a pairs 3 cycles apart, err = 0, count = 4; a fifth push of 0x55 → rvalid_a with err = 1, no stk_push, count stays 4.
- B pops four times from that state → rdata = 0x44, 0x33, 0x22, 0x11, count = 0; a fifth pop → err = 1, rdata = 0, no stk_pop.
- req_a and req_b asserted together, held continuously → grants alternate A, B, A, B, with each gnt exactly 3 cycles after the previous one.
- flush and req_a asserted together in IDLE at count = 2 → stk_reset pulse for one cycle, count = 0, then A is granted in the following IDLE; a pop by A → err = 1.
- Reset asserted during ISSUE of a pop at count = 3 → no rvalid, stk_reset = 1 while low, count = 0; after release a pop → err = 1.
- Check every cycle: at most one of stk_push/stk_pop/stk_reset high; gnt and rvalid always one-hot and one cycle wide.
